serial_frame_tx: RTL and testbench

Parallel-in, serial-out frame transmitter. It is the sending end of the team's single-wire serial link, whose receiver captures N-bit words into an enabled register.
- Accepts an N-bit word through a valid/ready handshake.
- Emits one frame on txd: start bit (0), N data bits LSB first, optional parity bit, stop bit (1).
- Every bit is held for CLKS_PER_BIT clocks.

---
 rtl/serial_frame_pkg.sv | 15 +
 rtl/bit_timer.sv | 33 +++
 rtl/serial_frame_tx.sv | 135 +++++++++++++
 tb/tb_serial_frame_tx.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_frame_pkg.sv
// Shared types and line constants for the single-wire serial frame transmitter.
package serial_frame_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic TXD_IDLE  = 1'b1;
  localparam logic START_BIT = 1'b0;

endpackage

// File: rtl/bit_timer.sv
// Bit-period timer: counts clocks while run is high and flags the last clock of each bit.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT == 0) begin : g_bad_cfg
    $error("bit_timer: CLKS_PER_BIT must be at least 1");
  end

  logic [CNT_W-1:0] cnt_q;

  // Counter restarts whenever the line goes idle so every frame starts phase-aligned.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (!run || (cnt_q == LAST)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign tick = run && (cnt_q == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-in, serial-out frame transmitter: start bit, N data bits LSB first,
// optional parity bit, stop bit, each held for CLKS_PER_BIT clocks.
module serial_frame_tx
  import serial_frame_pkg::*;
#(
  parameter int unsigned N            = 4,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] D,
  input  logic         valid,
  output logic         ready,
  output logic         txd,
  output logic         busy,
  output logic         done
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  tx_state_t        state_q, state_d;
  logic [N-1:0]     shreg_q, shreg_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             parity_q, parity_d;
  logic             txd_d, ready_d, busy_d, done_d;
  logic             tick;

  // busy is high exactly from START through STOP, so it doubles as the timer enable.
  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .run (busy),
    .tick(tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      idx_q    <= '0;
      parity_q <= 1'b0;
      txd      <= TXD_IDLE;
      ready    <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      idx_q    <= idx_d;
      parity_q <= parity_d;
      txd      <= txd_d;
      ready    <= ready_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  // Next-state and next-output logic; txd_d is the value the line takes on the coming edge.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    idx_d    = idx_q;
    parity_d = parity_q;
    txd_d    = txd;
    ready_d  = ready;
    busy_d   = busy;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        txd_d = TXD_IDLE;
        if (valid && ready) begin
          state_d  = START;
          shreg_d  = D;
          parity_d = (^D) ^ (PARITY_ODD != 0);
          txd_d    = START_BIT;
          ready_d  = 1'b0;
          busy_d   = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          txd_d   = shreg_q[0];
          shreg_d = shreg_q >> 1;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (tick) begin
          if (idx_q == LAST_IDX) begin
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              txd_d   = parity_q;
            end else begin
              state_d = STOP;
              txd_d   = TXD_IDLE;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            txd_d   = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          state_d = STOP;
          txd_d   = TXD_IDLE;
        end
      end
      STOP: begin
        if (tick) begin
          state_d = IDLE;
          txd_d   = TXD_IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        txd_d   = TXD_IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: three configurations checked every cycle against a
// frame-queue model, plus literal waveforms for the even/odd 4-bit frames.
module tb_serial_frame_tx;

  typedef struct packed {
    logic txd;
    logic ready;
    logic busy;
    logic done;
  } obs_t;

  localparam obs_t IDLE_OBS  = obs_t'(4'b1100);
  localparam obs_t DONE_OBS  = obs_t'(4'b1101);
  localparam int   F4        = 28;

  logic       clk;
  logic       rst;
  logic [3:0] din   [3];
  logic       vin   [3];
  logic       txd_o [3];
  logic       rdy_o [3];
  logic       busy_o[3];
  logic       done_o[3];

  int   vectors;
  int   miscompares;
  int   cyc;
  bit   chk_en;
  obs_t exp_o[3];
  obs_t mq[3][$];

  serial_frame_tx #(.N(4), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .D(din[0]), .valid(vin[0]),
    .ready(rdy_o[0]), .txd(txd_o[0]), .busy(busy_o[0]), .done(done_o[0]));

  serial_frame_tx #(.N(4), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .D(din[1]), .valid(vin[1]),
    .ready(rdy_o[1]), .txd(txd_o[1]), .busy(busy_o[1]), .done(done_o[1]));

  serial_frame_tx #(.N(3), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u_fast (
    .clk(clk), .rst(rst), .D(din[2][2:0]), .valid(vin[2]),
    .ready(rdy_o[2]), .txd(txd_o[2]), .busy(busy_o[2]), .done(done_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pn(input int i); return (i == 2) ? 3 : 4; endfunction
  function automatic int pc(input int i); return (i == 2) ? 1 : 4; endfunction
  function automatic int pe(input int i); return (i == 2) ? 0 : 1; endfunction
  function automatic int po(input int i); return (i == 1) ? 1 : 0; endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, want);
    end
  endtask

  // Model: an accept expands the whole frame into per-cycle observations, then a done cycle.
  task automatic model_step(input int i);
    logic b[$];
    logic p;
    if (mq[i].size() == 0 && vin[i]) begin
      p = (po(i) != 0);
      b.push_back(1'b0);
      for (int j = 0; j < pn(i); j++) begin
        b.push_back(din[i][j]);
        p ^= din[i][j];
      end
      if (pe(i) != 0) b.push_back(p);
      b.push_back(1'b1);
      foreach (b[k]) begin
        for (int c = 0; c < pc(i); c++) mq[i].push_back(obs_t'({b[k], 1'b0, 1'b1, 1'b0}));
      end
      mq[i].push_back(DONE_OBS);
    end
    if (mq[i].size() > 0) exp_o[i] = mq[i].pop_front();
    else exp_o[i] = IDLE_OBS;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        exp_o[i] = IDLE_OBS;
      end
    end else begin
      for (int i = 0; i < 3; i++) model_step(i);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++)
        chk($sformatf("model_inst%0d", i),
            32'({txd_o[i], rdy_o[i], busy_o[i], done_o[i]}), 32'(exp_o[i]));
    end
  end

  // Called just after an accept edge on a 4-bit, 4-clock instance; ends after the done edge.
  task automatic watch(input int i, input logic [6:0] bits, input string nm, output int done_at);
    int nbusy;
    nbusy   = 0;
    done_at = -1;
    for (int c = 0; c <= F4; c++) begin
      @(negedge clk);
      if (c < F4) begin
        chk({nm, "_txd"}, 32'(txd_o[i]), 32'(bits[c / 4]));
        chk({nm, "_ready"}, 32'(rdy_o[i]), 32'd0);
        if (busy_o[i]) nbusy++;
        @(posedge clk);
      end else begin
        chk({nm, "_end"}, 32'({txd_o[i], rdy_o[i], busy_o[i], done_o[i]}), 32'h0000000d);
        done_at = cyc;
      end
    end
    chk({nm, "_busy_len"}, 32'(nbusy), 32'(F4));
  endtask

  task automatic launch(input int i, input logic [3:0] d);
    @(negedge clk);
    #1 vin[i] = 1'b1;
    din[i] = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d1, d2, ndone;
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    chk_en      = 1'b0;
    rst         = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0;
      din[i] = 4'h0;
    end

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("reset_async_inst%0d", i),
          32'({txd_o[i], rdy_o[i], busy_o[i], done_o[i]}), 32'h0000000c);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;

    // Even parity 0xA, valid for one cycle.
    launch(0, 4'hA);
    vin[0] = 1'b0;
    watch(0, 7'b1010100, "even_A", d1);
    @(negedge clk);
    chk("even_A_done_one_cycle", 32'(done_o[0]), 32'd0);

    // Odd parity 0x3.
    launch(1, 4'h3);
    vin[1] = 1'b0;
    watch(1, 7'b1100110, "odd_3", d1);

    // valid held with 0x6 during the 0xA frame: ignored until the ready edge.
    launch(0, 4'hA);
    din[0] = 4'h6;
    watch(0, 7'b1010100, "hold_A", d1);
    @(posedge clk);
    #1 vin[0] = 1'b0;
    watch(0, 7'b1001100, "hold_6", d2);
    chk("hold_done_gap", 32'(d2 - d1), 32'd29);

    // Back-to-back 0x3 then 0x6.
    launch(0, 4'h3);
    din[0] = 4'h6;
    watch(0, 7'b1000110, "b2b_3", d1);
    @(posedge clk);
    #1 vin[0] = 1'b0;
    watch(0, 7'b1001100, "b2b_6", d2);
    chk("b2b_done_gap", 32'(d2 - d1), 32'd29);

    // Reset during the D[1] bit of a 0xA frame.
    launch(0, 4'hA);
    vin[0] = 1'b0;
    repeat (9) @(posedge clk);
    #2 chk("abort_busy_before", 32'(busy_o[0]), 32'd1);
    rst = 1'b0;
    #1 chk("abort_async", 32'({txd_o[0], rdy_o[0], busy_o[0], done_o[0]}), 32'h0000000c);
    @(negedge clk);
    #1 rst = 1'b1;
    ndone = 0;
    repeat (32) begin
      @(negedge clk);
      if (done_o[0]) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    launch(0, 4'h3);
    vin[0] = 1'b0;
    watch(0, 7'b1000110, "after_abort_3", d1);

    // Random traffic on all three configurations with occasional mid-cycle resets.
    for (int t = 0; t < 800; t++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < 3; i++) begin
        vin[i] = ($urandom_range(0, 3) != 0);
        din[i] = 4'($urandom);
      end
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b0;
        #2 rst = 1'b1;
      end
    end
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) vin[i] = 1'b0;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
